// File: rtl/tlb_op_ctrl.sv
// TLB management-op controller: sequences SRCH/RD/WR/FILL/INV through IDLE->EXEC->RESP.
// Optional feature macro TLB_FILL_LFSR_EN selects an LFSR fill pointer instead of an up-counter.
module tlb_op_ctrl #(
    parameter int TLB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [2:0]           op_code_i,
    input  logic [TLB_IDX_W-1:0] op_index_i,
    input  logic [4:0]           op_inv_i,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 srch_hit_o,
    output logic [TLB_IDX_W-1:0] srch_index_o,
    output logic                 tlb_s1_sel_o,
    input  logic                 tlb_s1_found_i,
    input  logic [TLB_IDX_W-1:0] tlb_s1_index_i,
    output logic                 tlb_we_o,
    output logic [TLB_IDX_W-1:0] tlb_w_index_o,
    output logic [TLB_IDX_W-1:0] tlb_r_index_o,
    output logic                 tlb_inv_valid_o,
    output logic [4:0]           tlb_inv_op_o,
    output logic                 tlb_busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    state_t                 state;
    logic [2:0]             op_code_q;
    logic [3:0]             fill_ptr;
    logic [TLB_IDX_W-1:0]   fill_index;

    // Free-running fill pointer; the LFSR variant never reaches 0, keeping entry 0 out of FILL.
`ifdef TLB_FILL_LFSR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_ptr <= 4'b0001;
        end else begin
            fill_ptr <= {fill_ptr[2:0], fill_ptr[3] ^ fill_ptr[2]};
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_ptr <= 4'b0000;
        end else begin
            fill_ptr <= fill_ptr + 4'd1;
        end
    end
`endif

    assign fill_index = TLB_IDX_W'(fill_ptr);

    // Strobes are registered at acceptance so they are high exactly for the EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            op_code_q       <= 3'd0;
            op_ready_o      <= 1'b1;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            srch_hit_o      <= 1'b0;
            srch_index_o    <= '0;
            tlb_s1_sel_o    <= 1'b0;
            tlb_we_o        <= 1'b0;
            tlb_w_index_o   <= '0;
            tlb_r_index_o   <= '0;
            tlb_inv_valid_o <= 1'b0;
            tlb_inv_op_o    <= 5'd0;
            tlb_busy_o      <= 1'b0;
        end else begin
            tlb_s1_sel_o    <= 1'b0;
            tlb_we_o        <= 1'b0;
            tlb_inv_valid_o <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (op_valid_i && op_ready_o) begin
                        state      <= EXEC;
                        op_code_q  <= op_code_i;
                        op_ready_o <= 1'b0;
                        tlb_busy_o <= 1'b1;
                        case (op_code_i)
                            OP_SRCH: tlb_s1_sel_o <= 1'b1;
                            OP_RD:   tlb_r_index_o <= op_index_i;
                            OP_WR: begin
                                tlb_we_o      <= 1'b1;
                                tlb_w_index_o <= op_index_i;
                            end
                            OP_FILL: begin
                                tlb_we_o      <= 1'b1;
                                tlb_w_index_o <= fill_index;
                            end
                            OP_INV: begin
                                tlb_inv_valid_o <= 1'b1;
                                tlb_inv_op_o    <= op_inv_i;
                            end
                            default: ;
                        endcase
                    end
                end
                EXEC: begin
                    state  <= RESP;
                    done_o <= 1'b1;
                    err_o  <= (op_code_q > OP_INV);
                    if (op_code_q == OP_SRCH) begin
                        srch_hit_o   <= tlb_s1_found_i;
                        srch_index_o <= tlb_s1_found_i ? tlb_s1_index_i : '0;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    op_ready_o <= 1'b1;
                    tlb_busy_o <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    op_ready_o <= 1'b1;
                    tlb_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: driver pushes expected EXEC strobes and responses,
// a negedge monitor pops and compares them. Honours TLB_FILL_LFSR_EN for the fill model.
module tb_tlb_op_ctrl;

    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          op_valid_i;
    logic          op_ready_o;
    logic [2:0]    op_code_i;
    logic [IW-1:0] op_index_i;
    logic [4:0]    op_inv_i;
    logic          done_o;
    logic          err_o;
    logic          srch_hit_o;
    logic [IW-1:0] srch_index_o;
    logic          tlb_s1_sel_o;
    logic          tlb_s1_found_i;
    logic [IW-1:0] tlb_s1_index_i;
    logic          tlb_we_o;
    logic [IW-1:0] tlb_w_index_o;
    logic [IW-1:0] tlb_r_index_o;
    logic          tlb_inv_valid_o;
    logic [4:0]    tlb_inv_op_o;
    logic          tlb_busy_o;

    tlb_op_ctrl #(.TLB_IDX_W(IW)) dut (
        .clk             (clk),
        .rst             (rst),
        .op_valid_i      (op_valid_i),
        .op_ready_o      (op_ready_o),
        .op_code_i       (op_code_i),
        .op_index_i      (op_index_i),
        .op_inv_i        (op_inv_i),
        .done_o          (done_o),
        .err_o           (err_o),
        .srch_hit_o      (srch_hit_o),
        .srch_index_o    (srch_index_o),
        .tlb_s1_sel_o    (tlb_s1_sel_o),
        .tlb_s1_found_i  (tlb_s1_found_i),
        .tlb_s1_index_i  (tlb_s1_index_i),
        .tlb_we_o        (tlb_we_o),
        .tlb_w_index_o   (tlb_w_index_o),
        .tlb_r_index_o   (tlb_r_index_o),
        .tlb_inv_valid_o (tlb_inv_valid_o),
        .tlb_inv_op_o    (tlb_inv_op_o),
        .tlb_busy_o      (tlb_busy_o)
    );

    typedef struct {
        int            t;
        logic          we;
        logic [IW-1:0] w_index;
        logic          is_fill;
        logic          inv_valid;
        logic [4:0]    inv_op;
        logic          s1_sel;
        logic          is_rd;
        logic [IW-1:0] r_index;
    } exec_t;

    typedef struct {
        int            t;
        logic          err;
        logic          hit;
        logic [IW-1:0] sidx;
        logic          is_rd;
        logic [IW-1:0] r_index;
    } resp_t;

    exec_t         exp_exec[$];
    resp_t         exp_resp[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            ncyc    = 0;
    int            fill_cyc = 0;
    logic          mon_en  = 1'b1;
    logic          last_hit = 1'b0;
    logic [IW-1:0] last_idx = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release: the fill pointer value is a pure function of this count.
    always @(posedge clk or posedge rst) begin
        if (rst) fill_cyc = 0;
        else     fill_cyc = fill_cyc + 1;
    end

    function automatic logic [IW-1:0] fill_model(input int n);
`ifdef TLB_FILL_LFSR_EN
        logic [3:0] v;
        v = 4'b0001;
        for (int i = 0; i < n % 15; i++) v = {v[2:0], v[3] ^ v[2]};
        return IW'(v);
`else
        return IW'(n % 16);
`endif
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic reset_checks();
        check_output("rst_ready",   op_ready_o, 1);
        check_output("rst_done",    done_o, 0);
        check_output("rst_err",     err_o, 0);
        check_output("rst_hit",     srch_hit_o, 0);
        check_output("rst_sidx",    srch_index_o, 0);
        check_output("rst_strobes", {tlb_we_o, tlb_inv_valid_o, tlb_s1_sel_o}, 0);
        check_output("rst_indices", {tlb_w_index_o, tlb_r_index_o, tlb_inv_op_o}, 0);
        check_output("rst_busy",    tlb_busy_o, 0);
    endtask

    task automatic idle_cycles(input int n);
        op_valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with the controller idle; returns at the negedge of T+3.
    task automatic apply_stimulus(input logic [2:0] code, input logic [IW-1:0] idx,
                                  input logic [4:0] inv, input logic found,
                                  input logic [IW-1:0] sidx, input logic hold);
        exec_t         e;
        resp_t         r;
        logic [IW-1:0] fidx;
        op_valid_i = 1'b1;
        op_code_i  = code;
        op_index_i = idx;
        op_inv_i   = inv;
        @(posedge clk);
        #1;
        fidx        = fill_model(fill_cyc - 1);
        e.t         = ncyc + 1;
        e.we        = (code == 3'd2) || (code == 3'd3);
        e.w_index   = (code == 3'd2) ? idx : fidx;
        e.is_fill   = (code == 3'd3);
        e.inv_valid = (code == 3'd4);
        e.inv_op    = inv;
        e.s1_sel    = (code == 3'd0);
        e.is_rd     = (code == 3'd1);
        e.r_index   = idx;
        exp_exec.push_back(e);
        if (code == 3'd0) begin
            last_hit = found;
            last_idx = found ? sidx : '0;
        end
        r.t       = ncyc + 2;
        r.err     = (code > 3'd4);
        r.hit     = last_hit;
        r.sidx    = last_idx;
        r.is_rd   = (code == 3'd1);
        r.r_index = idx;
        exp_resp.push_back(r);
        tlb_s1_found_i = found;
        tlb_s1_index_i = sidx;
        op_code_i  = 3'($urandom);
        op_index_i = IW'($urandom);
        op_inv_i   = 5'($urandom);
        op_valid_i = hold ? 1'b1 : 1'($urandom);
        repeat (2) @(negedge clk);
        tlb_s1_found_i = 1'($urandom);
        tlb_s1_index_i = IW'($urandom);
        @(negedge clk);
        check_output("ready_at_t3", op_ready_o, 1);
        check_output("idle_busy",   tlb_busy_o, 0);
        op_valid_i = 1'b0;
    endtask

    // Monitor: every negedge, compare EXEC strobes and RESP results against the queues.
    always @(negedge clk) begin
        exec_t e;
        resp_t r;
        ncyc = ncyc + 1;
        if (!rst && mon_en) begin
            if (exp_exec.size() > 0 && exp_exec[0].t == ncyc) begin
                e = exp_exec.pop_front();
                check_output("exec_we",        tlb_we_o, e.we);
                if (e.we) check_output("exec_w_index", tlb_w_index_o, e.w_index);
`ifdef TLB_FILL_LFSR_EN
                if (e.is_fill) check_output("fill_nonzero", (tlb_w_index_o != '0), 1);
`endif
                check_output("exec_inv_valid", tlb_inv_valid_o, e.inv_valid);
                if (e.inv_valid) check_output("exec_inv_op", tlb_inv_op_o, e.inv_op);
                check_output("exec_s1_sel",    tlb_s1_sel_o, e.s1_sel);
                if (e.is_rd) check_output("exec_r_index", tlb_r_index_o, e.r_index);
                check_output("exec_busy",      tlb_busy_o, 1);
                check_output("exec_ready",     op_ready_o, 0);
            end else begin
                check_output("no_strobe", {tlb_we_o, tlb_inv_valid_o, tlb_s1_sel_o}, 0);
            end
            if (done_o) begin
                if (exp_resp.size() > 0 && exp_resp[0].t == ncyc) begin
                    r = exp_resp.pop_front();
                    check_output("resp_err",  err_o, r.err);
                    check_output("resp_hit",  srch_hit_o, r.hit);
                    check_output("resp_sidx", srch_index_o, r.sidx);
                    if (r.is_rd) check_output("resp_r_index", tlb_r_index_o, r.r_index);
                    check_output("resp_busy",  tlb_busy_o, 1);
                    check_output("resp_ready", op_ready_o, 0);
                end else begin
                    check_output("done_unexpected", done_o, 0);
                end
            end else if (exp_resp.size() > 0 && exp_resp[0].t <= ncyc) begin
                void'(exp_resp.pop_front());
                check_output("done_missing", done_o, 1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        op_valid_i     = 1'b0;
        op_code_i      = 3'd0;
        op_index_i     = '0;
        op_inv_i       = 5'd0;
        tlb_s1_found_i = 1'b0;
        tlb_s1_index_i = '0;
        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b0;

        // FILL accepted with the pointer three steps past reset.
        idle_cycles(3);
        apply_stimulus(3'd3, 4'd0, 5'd0, 1'b0, 4'd0, 1'b0);
        apply_stimulus(3'd2, 4'd5, 5'd0, 1'b0, 4'd0, 1'b0);
        apply_stimulus(3'd0, 4'd0, 5'd0, 1'b1, 4'd9, 1'b0);
        apply_stimulus(3'd1, 4'd7, 5'd0, 1'b1, 4'd3, 1'b0);
        apply_stimulus(3'd0, 4'd0, 5'd0, 1'b0, 4'd9, 1'b0);
        apply_stimulus(3'd6, 4'd2, 5'd0, 1'b0, 4'd0, 1'b0);
        apply_stimulus(3'd4, 4'd0, 5'd5, 1'b0, 4'd0, 1'b1);
        apply_stimulus(3'd2, 4'd12, 5'd0, 1'b0, 4'd0, 1'b1);
        idle_cycles(2);

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(3'd3, IW'($urandom), 5'($urandom), 1'($urandom), IW'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        for (int i = 0; i < 60; i++) begin
            apply_stimulus(3'($urandom_range(0, 7)), IW'($urandom), 5'($urandom),
                           1'($urandom), IW'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        // Reset in the middle of a WR's EXEC cycle must kill the strobe and the response.
        idle_cycles(1);
        mon_en     = 1'b0;
        op_valid_i = 1'b1;
        op_code_i  = 3'd2;
        op_index_i = 4'd5;
        @(posedge clk);
        #1;
        op_valid_i = 1'b0;
        @(negedge clk);
        check_output("abort_we_before", tlb_we_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check_output("abort_we_after", tlb_we_o, 0);
        reset_checks();
        @(negedge clk);
        rst      = 1'b0;
        last_hit = 1'b0;
        last_idx = '0;
        mon_en   = 1'b1;
        idle_cycles(3);
        apply_stimulus(3'd3, 4'd0, 5'd0, 1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(3'($urandom_range(0, 7)), IW'($urandom), 5'($urandom),
                           1'($urandom), IW'($urandom), 1'($urandom));
        end

        idle_cycles(4);
        check_output("queue_drain", exp_exec.size() + exp_resp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
